// File: rtl/frame_pkg.sv
// Shared frame-memory definitions: {y, x} address layout and the pixel beat format
// used by the frame writers and by binary_frame_reader.
package frame_pkg;

    localparam int ADDR_W = 19;
    localparam int X_W    = 10;
    localparam int Y_W    = 9;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} reader_state_t;

    typedef struct packed {
        logic           pixel;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic           eol;
        logic           last;
    } pixel_beat_t;

    // Beat metadata that rides along the read-latency pipe ahead of the pixel value.
    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic           eol;
        logic           last;
    } beat_tag_t;

    function automatic logic [ADDR_W-1:0] pack_addr(input logic [Y_W-1:0] y,
                                                    input logic [X_W-1:0] x);
        return {y, x};
    endfunction

endpackage

// File: rtl/beat_fifo.sv
// Small synchronous FIFO of pixel beats; any DEPTH >= 2, push and pop may coincide
// when full (pop when empty is ignored).
module beat_fifo
    import frame_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  pixel_beat_t push_data,
    input  logic        pop,
    output pixel_beat_t pop_data,
    output logic        empty,
    output logic        full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    pixel_beat_t   mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    always_comb begin
        empty   = (cnt_q == '0);
        full    = (cnt_q == CW'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d    = wr_q;
        rd_d    = rd_q;
        if (do_push) wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
        if (do_pop)  rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_q];

endmodule

// File: rtl/binary_frame_reader.sv
// Streams a 1-bpp frame from memory in raster order as a valid/ready beat stream,
// using credit-based read issue so the output FIFO can never overflow.
module binary_frame_reader
    import frame_pkg::*;
#(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] read_addr,
    output logic              read_en,
    input  logic              read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_pixel,
    output logic [X_W-1:0]    out_x,
    output logic [Y_W-1:0]    out_y,
    output logic              out_eol,
    output logic              out_last
);
    localparam int FIFO_DEPTH = READ_LATENCY + 2;
    localparam int CW         = $clog2(FIFO_DEPTH + 1);

    reader_state_t         state_q, state_d;
    logic [X_W-1:0]        fx_q, fx_d, ix;
    logic [Y_W-1:0]        fy_q, fy_d, iy;
    logic [CW-1:0]         credits_q, credits_d;
    logic                  read_en_q, read_en_d;
    logic [ADDR_W-1:0]     read_addr_q, read_addr_d;
    logic                  busy_q, busy_d, done_q, done_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic                  issue, pop, fifo_empty, fifo_full_unused;
    beat_tag_t             tag_q [READ_LATENCY];
    pixel_beat_t           push_beat, head;

    assign pop = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        fx_d        = fx_q;
        fy_d        = fy_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        read_en_d   = 1'b0;
        read_addr_d = read_addr_q;
        issue       = 1'b0;
        ix          = fx_q;
        iy          = fy_q;
        credits_d   = credits_q - CW'(read_en_q) + CW'(pop);
        vld_d[0]    = read_en_q;
        for (int i = 1; i < READ_LATENCY; i++) vld_d[i] = vld_q[i-1];

        case (state_q)
            IDLE: if (start) begin
                issue  = 1'b1;
                ix     = '0;
                iy     = '0;
                busy_d = 1'b1;
            end
            FETCH:  issue = (credits_d != '0);
            DRAIN: if (pop && out_last) begin
                state_d = FINISH;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // fx/fy always hold the next coordinate to fetch
        if (issue) begin
            read_en_d   = 1'b1;
            read_addr_d = pack_addr(iy, ix);
            if (ix == X_W'(WIDTH - 1)) begin
                fx_d = '0;
                fy_d = iy + 1'b1;
            end else begin
                fx_d = ix + 1'b1;
                fy_d = iy;
            end
            state_d = (ix == X_W'(WIDTH - 1) && iy == Y_W'(HEIGHT - 1)) ? DRAIN : FETCH;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            fx_q        <= '0;
            fy_q        <= '0;
            credits_q   <= CW'(FIFO_DEPTH);
            read_en_q   <= 1'b0;
            read_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            vld_q       <= '0;
        end else begin
            state_q     <= state_d;
            fx_q        <= fx_d;
            fy_q        <= fy_d;
            credits_q   <= credits_d;
            read_en_q   <= read_en_d;
            read_addr_q <= read_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            vld_q       <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q[0] <= '{x:    read_addr_q[X_W-1:0],
                      y:    read_addr_q[ADDR_W-1:X_W],
                      eol:  read_addr_q[X_W-1:0] == X_W'(WIDTH - 1),
                      last: read_addr_q == pack_addr(Y_W'(HEIGHT - 1), X_W'(WIDTH - 1))};
        for (int i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end

    assign push_beat = '{pixel: read_data,
                         x:     tag_q[READ_LATENCY-1].x,
                         y:     tag_q[READ_LATENCY-1].y,
                         eol:   tag_q[READ_LATENCY-1].eol,
                         last:  tag_q[READ_LATENCY-1].last};

    beat_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (vld_q[READ_LATENCY-1]),
        .push_data (push_beat),
        .pop       (pop),
        .pop_data  (head),
        .empty     (fifo_empty),
        .full      (fifo_full_unused)
    );

    // Payload is masked so every output reads 0 whenever no beat is presented
    assign out_valid = !fifo_empty;
    assign out_pixel = out_valid & head.pixel;
    assign out_x     = out_valid ? head.x : '0;
    assign out_y     = out_valid ? head.y : '0;
    assign out_eol   = out_valid & head.eol;
    assign out_last  = out_valid & head.last;
    assign busy      = busy_q;
    assign done      = done_q;
    assign read_en   = read_en_q;
    assign read_addr = read_addr_q;

endmodule

// File: tb/tb_binary_frame_reader.sv
// Bench for binary_frame_reader: four instances (4x3 L=2, 640x4 L=2, 4x3 L=1, 4x3 L=4)
// driven one at a time against a raster-order reference of the frame memory.
module tb_binary_frame_reader;

    typedef struct packed {
        logic       px;
        logic [9:0] x;
        logic [8:0] y;
        logic       eol;
        logic       last;
    } beat_t;

    localparam int W_P [0:3] = '{4, 640, 4, 4};
    localparam int H_P [0:3] = '{3, 4, 3, 3};
    localparam int L_P [0:3] = '{2, 2, 1, 4};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    bit mem [0:524287];

    logic        rn [4];
    logic        st [4];
    logic        rdy [4];
    logic        busy [4];
    logic        done [4];
    logic [18:0] raddr [4];
    logic        ren [4];
    logic        ov [4];
    logic        opx [4];
    logic [9:0]  ox [4];
    logic [8:0]  oy [4];
    logic        oeol [4];
    logic        olast [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int L = L_P[g];
        bit dly [L];
        always @(posedge clk) begin
            dly[0] <= mem[raddr[g]];
            for (int i = 1; i < L; i++) dly[i] <= dly[i-1];
        end
        binary_frame_reader #(.WIDTH(W_P[g]), .HEIGHT(H_P[g]), .READ_LATENCY(L)) u_dut (
            .clk       (clk),
            .reset     (rn[g]),
            .start     (st[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .read_addr (raddr[g]),
            .read_en   (ren[g]),
            .read_data (dly[L-1]),
            .out_valid (ov[g]),
            .out_ready (rdy[g]),
            .out_pixel (opx[g]),
            .out_x     (ox[g]),
            .out_y     (oy[g]),
            .out_eol   (oeol[g]),
            .out_last  (olast[g])
        );
    end

    int n_checks = 0;
    int n_errors = 0;

    beat_t       obs [$];
    logic [18:0] iss [$];
    int first_vld, done_cyc, done_cnt, max_out, unstable, timed_out;
    int post_act, reset_bad, reset_seen, gaps;
    logic c1_busy, c1_ren, busy_at_done;
    logic [18:0] c1_addr;

    function automatic beat_t exp_beat(input int s, input int k);
        beat_t b;
        int x, y;
        logic [9:0] xv;
        logic [8:0] yv;
        x = k % W_P[s];
        y = k / W_P[s];
        xv = x[9:0];
        yv = y[8:0];
        b.px   = mem[{yv, xv}];
        b.x    = xv;
        b.y    = yv;
        b.eol  = (x == W_P[s] - 1);
        b.last = (k == W_P[s] * H_P[s] - 1);
        return b;
    endfunction

    task automatic fill_xor(input int s);
        logic [9:0] xv;
        logic [8:0] yv;
        for (int y = 0; y < H_P[s]; y++)
            for (int x = 0; x < W_P[s]; x++) begin
                xv = x[9:0];
                yv = y[8:0];
                mem[{yv, xv}] = xv[0] ^ yv[0];
            end
    endtask

    task automatic fill_rand(input int s);
        logic [9:0] xv;
        logic [8:0] yv;
        for (int y = 0; y < H_P[s]; y++)
            for (int x = 0; x < W_P[s]; x++) begin
                xv = x[9:0];
                yv = y[8:0];
                mem[{yv, xv}] = 1'($urandom);
            end
    endtask

    // Drives one frame on instance s and records what the stream and read port did.
    task automatic run(input int s, input int stall_at, input int stall_len, input bit rand_rdy,
                       input int restart_cyc, input int reset_at, input int max_cyc);
        int n_pop, stall_cnt, first_rd, last_rd, post;
        bit held, stop;
        beat_t prev, cur;
        obs.delete();
        iss.delete();
        first_vld = -1; done_cyc = -1; done_cnt = 0; max_out = 0; unstable = 0;
        timed_out = 0; post_act = 0; reset_bad = 0; reset_seen = 0; gaps = 0;
        c1_busy = 1'b0; c1_ren = 1'b0; c1_addr = '1; busy_at_done = 1'b1;
        n_pop = 0; stall_cnt = 0; first_rd = -1; last_rd = -1; post = -1;
        held = 1'b0; stop = 1'b0; prev = '0;
        @(negedge clk);
        st[s] = 1'b1;
        rdy[s] = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= max_cyc && !stop; c++) begin
            @(negedge clk);
            st[s] = (c == restart_cyc);
            if (reset_at >= 0 && obs.size() == reset_at) begin
                rn[s] = 1'b0;
                st[s] = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    #1;
                    if ({busy[s], done[s], ren[s], raddr[s], ov[s], opx[s], ox[s], oy[s],
                         oeol[s], olast[s]} !== '0) reset_bad++;
                    @(negedge clk);
                end
                rn[s] = 1'b1;
                reset_seen = 1;
                @(negedge clk);
                return;
            end
            if (rand_rdy) rdy[s] = 1'($urandom);
            else if (obs.size() == stall_at && stall_cnt < stall_len) begin
                rdy[s] = 1'b0;
                stall_cnt++;
            end else rdy[s] = 1'b1;
            #1;
            if (c == 1) begin
                c1_busy = busy[s];
                c1_ren  = ren[s];
                c1_addr = raddr[s];
            end
            if (ren[s]) begin
                iss.push_back(raddr[s]);
                if (first_rd < 0) first_rd = c;
                last_rd = c;
            end
            if (iss.size() - n_pop > max_out) max_out = iss.size() - n_pop;
            cur = '{px: opx[s], x: ox[s], y: oy[s], eol: oeol[s], last: olast[s]};
            if (ov[s]) begin
                if (first_vld < 0) first_vld = c;
                if (held && cur !== prev) unstable++;
                held = !rdy[s];
                prev = cur;
                if (rdy[s]) begin
                    obs.push_back(cur);
                    n_pop++;
                end
            end else begin
                if (held) unstable++;
                held = 1'b0;
            end
            if (done[s]) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    busy_at_done = busy[s];
                    post = c;
                end
            end
            if (post >= 0 && c > post && (ren[s] || busy[s])) post_act++;
            if (post >= 0 && c >= post + 6) stop = 1'b1;
        end
        if (done_cyc < 0) timed_out = 1;
        gaps = (first_rd < 0) ? 0 : (last_rd - first_rd + 1) - iss.size();
        st[s] = 1'b0;
        rdy[s] = 1'b1;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            n_checks++;
            if ({busy[s], done[s], ren[s], raddr[s], ov[s], opx[s], ox[s], oy[s], oeol[s],
                 olast[s]} !== '0) begin
                n_errors++;
                $display("FAIL reset_outputs inst %0d: busy=%b ren=%b addr=%h valid=%b, all required 0",
                         s, busy[s], ren[s], raddr[s], ov[s]);
            end
        end
        for (int s = 0; s < 4; s++) rn[s] = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_raster;
        beat_t e;
        fill_xor(0);
        run(0, -1, 0, 1'b0, -1, -1, 200);
        n_checks++;
        if ({c1_busy, c1_ren, c1_addr} !== {1'b1, 1'b1, 19'd0}) begin
            n_errors++;
            $display("FAIL raster_cycle1: busy=%b ren=%b addr=%h, required 1 1 0", c1_busy, c1_ren, c1_addr);
        end
        n_checks++;
        if (first_vld !== 4) begin
            n_errors++;
            $display("FAIL raster_first_valid: cycle %0d, required 4", first_vld);
        end
        n_checks++;
        if (obs.size() !== 12) begin
            n_errors++;
            $display("FAIL raster_count: %0d beats, required 12", obs.size());
        end
        for (int k = 0; k < obs.size() && k < 12; k++) begin
            e = exp_beat(0, k);
            n_checks++;
            if (obs[k] !== e) begin
                n_errors++;
                $display("FAIL raster_beat %0d: got %h, required %h", k, obs[k], e);
            end
        end
        n_checks++;
        if (done_cyc !== 16 || done_cnt !== 1 || busy_at_done !== 1'b0) begin
            n_errors++;
            $display("FAIL raster_done: cycle %0d count %0d busy %b, required 16 1 0",
                     done_cyc, done_cnt, busy_at_done);
        end
        n_checks++;
        if (gaps !== 0) begin
            n_errors++;
            $display("FAIL raster_full_rate: %0d idle read cycles, required 0", gaps);
        end
    endtask

    task automatic test_backpressure;
        beat_t e;
        fill_xor(0);
        run(0, 2, 10, 1'b0, -1, -1, 300);
        n_checks++;
        if (max_out > 4 || gaps <= 0) begin
            n_errors++;
            $display("FAIL bp_credits: max outstanding %0d gaps %0d, required <=4 and >0", max_out, gaps);
        end
        n_checks++;
        if (unstable !== 0) begin
            n_errors++;
            $display("FAIL bp_hold: %0d payload changes while stalled, required 0", unstable);
        end
        n_checks++;
        if (obs.size() !== 12) begin
            n_errors++;
            $display("FAIL bp_count: %0d beats, required 12", obs.size());
        end
        for (int k = 0; k < obs.size() && k < 12; k++) begin
            e = exp_beat(0, k);
            n_checks++;
            if (obs[k] !== e) begin
                n_errors++;
                $display("FAIL bp_beat %0d: got %h, required %h", k, obs[k], e);
            end
        end
        n_checks++;
        if (done_cyc !== 26 || done_cnt !== 1) begin
            n_errors++;
            $display("FAIL bp_done: cycle %0d count %0d, required 26 1", done_cyc, done_cnt);
        end
    endtask

    task automatic test_random_ready;
        beat_t e;
        int shown;
        logic [18:0] a641;
        a641 = {9'd1, 10'd1};
        shown = 0;
        fill_rand(1);
        run(1, -1, 0, 1'b1, -1, -1, 20000);
        n_checks++;
        if (obs.size() !== 2560) begin
            n_errors++;
            $display("FAIL rand_count: %0d beats, required 2560", obs.size());
        end
        for (int k = 0; k < obs.size() && k < 2560; k++) begin
            e = exp_beat(1, k);
            n_checks++;
            if (obs[k] !== e) begin
                n_errors++;
                if (shown < 5) $display("FAIL rand_beat %0d: got %h, required %h", k, obs[k], e);
                shown++;
            end
        end
        n_checks++;
        if (iss.size() < 642 || iss[641] !== a641) begin
            n_errors++;
            $display("FAIL rand_addr641: got %h (of %0d reads), required %h",
                     (iss.size() > 641) ? iss[641] : 19'h7ffff, iss.size(), a641);
        end
        n_checks++;
        if (done_cnt !== 1 || timed_out !== 0 || max_out > 4 || unstable !== 0) begin
            n_errors++;
            $display("FAIL rand_done: done %0d timeout %0d outstanding %0d unstable %0d, required 1 0 <=4 0",
                     done_cnt, timed_out, max_out, unstable);
        end
    endtask

    task automatic test_start_ignored;
        fill_xor(0);
        run(0, -1, 0, 1'b0, 5, -1, 200);
        n_checks++;
        if (done_cnt !== 1 || done_cyc !== 16 || obs.size() !== 12 || post_act !== 0) begin
            n_errors++;
            $display("FAIL start_busy: done %0d at %0d beats %0d after %0d, required 1 16 12 0",
                     done_cnt, done_cyc, obs.size(), post_act);
        end
        run(0, -1, 0, 1'b0, 16, -1, 200);
        n_checks++;
        if (done_cnt !== 1 || post_act !== 0) begin
            n_errors++;
            $display("FAIL start_finish: done %0d activity after %0d, required 1 0", done_cnt, post_act);
        end
    endtask

    task automatic test_reset_mid_frame;
        beat_t e;
        fill_xor(0);
        run(0, -1, 0, 1'b0, -1, 6, 200);
        n_checks++;
        if (reset_seen !== 1 || reset_bad !== 0 || obs.size() !== 6 || done_cnt !== 0) begin
            n_errors++;
            $display("FAIL midreset_outputs: seen %0d nonzero %0d beats %0d done %0d, required 1 0 6 0",
                     reset_seen, reset_bad, obs.size(), done_cnt);
        end
        run(0, -1, 0, 1'b0, -1, -1, 200);
        n_checks++;
        if (first_vld !== 4 || obs.size() !== 12 || done_cyc !== 16) begin
            n_errors++;
            $display("FAIL midreset_restart: first %0d beats %0d done %0d, required 4 12 16",
                     first_vld, obs.size(), done_cyc);
        end
        for (int k = 0; k < obs.size() && k < 12; k++) begin
            e = exp_beat(0, k);
            n_checks++;
            if (obs[k] !== e) begin
                n_errors++;
                $display("FAIL midreset_beat %0d: got %h, required %h", k, obs[k], e);
            end
        end
    endtask

    task automatic test_latency_variants;
        beat_t e;
        for (int s = 2; s < 4; s++) begin
            fill_rand(s);
            run(s, -1, 0, 1'b0, -1, -1, 200);
            n_checks++;
            if (first_vld !== 2 + L_P[s] || done_cyc !== 14 + L_P[s] || gaps !== 0) begin
                n_errors++;
                $display("FAIL latency_%0d: first %0d done %0d gaps %0d, required %0d %0d 0",
                         L_P[s], first_vld, done_cyc, gaps, 2 + L_P[s], 14 + L_P[s]);
            end
            n_checks++;
            if (obs.size() !== 12) begin
                n_errors++;
                $display("FAIL latency_%0d_count: %0d beats, required 12", L_P[s], obs.size());
            end
            for (int k = 0; k < obs.size() && k < 12; k++) begin
                e = exp_beat(s, k);
                n_checks++;
                if (obs[k] !== e) begin
                    n_errors++;
                    $display("FAIL latency_%0d_beat %0d: got %h, required %h", L_P[s], k, obs[k], e);
                end
            end
        end
    endtask

    initial begin
        for (int s = 0; s < 4; s++) begin
            rn[s] = 1'b0;
            st[s] = 1'b0;
            rdy[s] = 1'b1;
        end
        test_reset();
        test_raster();
        test_backpressure();
        test_random_ready();
        test_start_ignored();
        test_reset_mid_frame();
        test_latency_variants();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
